// File: rtl/nn_pkg.sv
// Shared definitions for the hidden-layer sequencer: default sizes, the
// sequencer state encoding and the lane-packing helper for the x/w buses.
package nn_pkg;

  localparam int DEF_DW         = 17;
  localparam int DEF_N_IN       = 8;
  localparam int DEF_N_NEURON   = 8;
  localparam int DEF_NEURON_LAT = 5;

  // LOAD collects activations, ISSUE streams weight addresses, WAIT lets the
  // neuron pipeline empty, DRAIN hands the results to the next layer.
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_e;

  // Low bit of lane 'lane' in a packed bus of 'width'-bit lanes (lane 0 at the LSBs).
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth shift register carrying (valid, tag) pairs. A weight read
// issued with tag n pops out of the tap exactly DEPTH cycles later, which is
// when the neuron's output for that read is on ny.
module tag_delay_line #(
  parameter int DEPTH = 6,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [AW-1:0] in_tag,
  output logic          out_valid,
  output logic [AW-1:0] out_tag
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    tag_q [DEPTH];
  logic [AW-1:0]    tag_d [DEPTH];

  // Next contents: everything moves one stage toward the tap.
  always_comb begin
    vld_d    = {vld_q[DEPTH-2:0], in_valid};
    tag_d[0] = in_tag;
    for (int i = 1; i < DEPTH; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Stage registers; reset empties the line so no stale capture can fire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/hidden_layer_seq.sv
// Time-multiplexes one neuron_hidden instance over a whole hidden layer:
// gathers N_IN serial activations into nx, streams one weight word per
// neuron, captures each pipelined ny by tag, then drains the results.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready/out_valid depend only on registered state, never
// on in_valid/out_ready, and out_data/out_idx stay put while out_valid is
// high and out_ready is low.
module hidden_layer_seq
  import nn_pkg::*;
#(
  parameter int N_IN       = DEF_N_IN,
  parameter int N_NEURON   = DEF_N_NEURON,
  parameter int DW         = DEF_DW,
  parameter int NEURON_LAT = DEF_NEURON_LAT,
  parameter int AW         = $clog2(N_NEURON)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  output logic                 w_rd,
  output logic [AW-1:0]        w_addr,
  input  logic [N_IN*DW-1:0]   w_data,
  output logic [N_IN*DW-1:0]   nx,
  output logic [N_IN*DW-1:0]   nw,
  output logic                 nce,
  input  logic [DW-1:0]        ny,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [AW-1:0]        out_idx,
  output logic                 busy
);

  localparam int            IW       = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int            XW       = N_IN * DW;
  localparam logic [IW-1:0] IN_LAST  = IW'(N_IN - 1);
  localparam logic [AW-1:0] NRN_LAST = AW'(N_NEURON - 1);

  seq_state_e    state_q, state_d;
  logic [IW-1:0] in_cnt_q, in_cnt_d;
  logic [AW-1:0] iss_cnt_q, iss_cnt_d;
  logic [AW-1:0] out_cnt_q, out_cnt_d;
  logic [XW-1:0] nx_q, nx_d;
  logic [DW-1:0] res_q [N_NEURON];
  logic [DW-1:0] res_d [N_NEURON];

  logic          tap_valid;
  logic [AW-1:0] tap_tag;

  // Issue strobe and neuron index travel together; the tap marks the cycle
  // the matching ny is valid (one ROM cycle plus the neuron latency).
  tag_delay_line #(
    .DEPTH (1 + NEURON_LAT),
    .AW    (AW)
  ) u_tag_dl (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_rd),
    .in_tag    (w_addr),
    .out_valid (tap_valid),
    .out_tag   (tap_tag)
  );

  // Sequencer next state, counters, activation lanes and result capture.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    iss_cnt_d = iss_cnt_q;
    out_cnt_d = out_cnt_q;
    nx_d      = nx_q;
    res_d     = res_q;

    unique case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          for (int k = 0; k < N_IN; k++) begin
            if (in_cnt_q == IW'(k)) begin
              nx_d[lane_lo(k, DW) +: DW] = in_data;
            end
          end
          if (in_cnt_q == IN_LAST) begin
            in_cnt_d = '0;
            state_d  = ST_ISSUE;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (iss_cnt_q == NRN_LAST) begin
          iss_cnt_d = '0;
          state_d   = ST_WAIT;
        end else begin
          iss_cnt_d = iss_cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        // The last tag leaving the line is the final capture of the pass.
        if (tap_valid && (tap_tag == NRN_LAST)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (out_cnt_q == NRN_LAST) begin
            out_cnt_d = '0;
            state_d   = ST_LOAD;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
    endcase

    // Captures start while still issuing, so they are not tied to one state.
    for (int i = 0; i < N_NEURON; i++) begin
      if (tap_valid && (tap_tag == AW'(i))) begin
        res_d[i] = ny;
      end
    end
  end

  // State and datapath registers; reset drops any partial pass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      in_cnt_q  <= '0;
      iss_cnt_q <= '0;
      out_cnt_q <= '0;
      nx_q      <= '0;
      for (int i = 0; i < N_NEURON; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      iss_cnt_q <= iss_cnt_d;
      out_cnt_q <= out_cnt_d;
      nx_q      <= nx_d;
      res_q     <= res_d;
    end
  end

  // Output decode from registered state only; counters idle at zero so
  // w_addr and out_idx read 0 outside their own phases.
  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    busy      = (state_q != ST_LOAD);
    w_rd      = (state_q == ST_ISSUE);
    w_addr    = iss_cnt_q;
    nce       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    out_valid = (state_q == ST_DRAIN);
    out_data  = (state_q == ST_DRAIN) ? res_q[out_cnt_q] : '0;
    out_idx   = out_cnt_q;
    nx        = nx_q;
    nw        = w_data;
  end

endmodule

// File: tb/tb_hidden_layer_seq.sv
// Bench for hidden_layer_seq: a weight ROM model, a 5-stage neuron model and
// a scoreboard of expected drained results per pass.
module tb_hidden_layer_seq;

  localparam int N_IN       = 8;
  localparam int N_NEURON   = 8;
  localparam int DW         = 17;
  localparam int NEURON_LAT = 5;
  localparam int AW         = 3;
  localparam int XW         = N_IN * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          w_rd;
  logic [AW-1:0] w_addr;
  logic [XW-1:0] w_data = '0;
  logic [XW-1:0] nx;
  logic [XW-1:0] nw;
  logic          nce;
  logic [DW-1:0] ny;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          busy;

  int            n_checks = 0;
  int            n_pass = 0;
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] idx_q [$];
  logic [XW-1:0] rom [N_NEURON];
  bit            lit_mode = 1'b0;
  logic [DW-1:0] npipe [NEURON_LAT];

  hidden_layer_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .w_rd      (w_rd),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .nx        (nx),
    .nw        (nw),
    .nce       (nce),
    .ny        (ny),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- models ----------------
  function automatic logic [XW-1:0] rand_word();
    logic [XW-1:0] w;
    for (int k = 0; k < N_IN; k++) w[k*DW +: DW] = DW'($urandom);
    return w;
  endfunction

  // Stand-in neuron function; literal mode gives y = 100 + lane0 of w.
  function automatic logic [DW-1:0] neuron_f(input logic [XW-1:0] x,
                                             input logic [XW-1:0] w,
                                             input bit lit);
    logic [DW-1:0] acc;
    acc = '0;
    if (lit) return DW'(100) + w[DW-1:0];
    for (int k = 0; k < N_IN; k++) acc = acc + (x[k*DW +: DW] ^ w[k*DW +: DW]) + DW'(k);
    return acc;
  endfunction

  // Weight ROM: word valid one cycle after w_rd, noise otherwise.
  always @(posedge clk) begin
    if (w_rd) w_data <= rom[w_addr];
    else      w_data <= rand_word();
  end

  // Neuron: fixed NEURON_LAT-cycle pipeline advancing only on nce.
  always @(posedge clk) begin
    if (nce) begin
      npipe[0] <= neuron_f(nx, nw, lit_mode);
      for (int i = 1; i < NEURON_LAT; i++) npipe[i] <= npipe[i-1];
    end
  end
  assign ny = npipe[NEURON_LAT-1];

  // ---------------- check helpers ----------------
  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
  endtask

  task automatic chk_w(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired, actual=pending expected=done", name);
  endtask

  task automatic check_reset_vals(input string tag);
    chk_i({tag, "_in_ready"},  int'(in_ready), 1);
    chk_i({tag, "_w_rd"},      int'(w_rd), 0);
    chk_i({tag, "_w_addr"},    int'(w_addr), 0);
    chk_i({tag, "_nce"},       int'(nce), 0);
    chk_i({tag, "_out_valid"}, int'(out_valid), 0);
    chk_i({tag, "_out_data"},  int'(out_data), 0);
    chk_i({tag, "_out_idx"},   int'(out_idx), 0);
    chk_i({tag, "_busy"},      int'(busy), 0);
    chk_w({tag, "_nx"},        nx, '0);
  endtask

  // ---------------- scoreboard / compare ----------------
  initial begin : compare
    bit            pstall;
    logic [DW-1:0] pdata;
    logic [AW-1:0] pidx;
    pstall = 1'b0;
    pdata  = '0;
    pidx   = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        chk_w("nw_passthru", nw, w_data);
        if (pstall && out_valid) begin
          chk_i("hold_data", int'(out_data), int'(pdata));
          chk_i("hold_idx",  int'(out_idx),  int'(pidx));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_out");
          else begin
            chk_w("out_data", XW'(out_data), XW'(exp_q.pop_front()));
            chk_i("out_idx", int'(out_idx), int'(idx_q.pop_front()));
          end
        end
        pstall = out_valid && !out_ready;
        pdata  = out_data;
        pidx   = out_idx;
      end else begin
        pstall = 1'b0;
      end
    end
  end

  // ---------------- driver: one full pass ----------------
  // gap: idle cycles before each sample; rdy_mode 0=always, 1=1,0,0 pattern,
  // 2=random; rst_at: pass-relative cycle at which to pulse reset (-1 none).
  task automatic run_pass(input bit lit, input int gap, input int rdy_mode, input int rst_at);
    logic [DW-1:0] xs [N_IN];
    logic [XW-1:0] exp_nx;
    int            c;
    lit_mode = lit;
    for (int n = 0; n < N_NEURON; n++) rom[n] = lit ? {N_IN{DW'(n)}} : rand_word();
    for (int k = 0; k < N_IN; k++) xs[k] = lit ? DW'(k + 1) : DW'($urandom);
    for (int k = 0; k < N_IN; k++) exp_nx[k*DW +: DW] = xs[k];

    for (int k = 0; k < N_IN; k++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = DW'($urandom);
        out_ready = 1'($urandom);
      end
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = xs[k];
      out_ready = 1'($urandom);
      chk_i("load_in_ready", int'(in_ready), 1);
      chk_i("load_busy", int'(busy), 0);
    end

    for (int n = 0; n < N_NEURON; n++) begin
      exp_q.push_back(lit ? DW'(100 + n) : neuron_f(exp_nx, rom[n], 1'b0));
      idx_q.push_back(AW'(n));
    end

    for (int i = 0; i < N_NEURON + NEURON_LAT + 1; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      in_data   = DW'($urandom);
      out_ready = 1'($urandom);
      chk_i("issue_w_rd", int'(w_rd), int'(i < N_NEURON));
      if (i < N_NEURON) chk_i("issue_w_addr", int'(w_addr), i);
      chk_i("pass_nce", int'(nce), 1);
      chk_i("pass_in_ready", int'(in_ready), 0);
      chk_i("pass_busy", int'(busy), 1);
      chk_i("pass_out_valid", int'(out_valid), 0);
      chk_w("pass_nx", nx, exp_nx);
      if (i == rst_at) begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        rst_n = 1'b1;
        exp_q.delete();
        idx_q.delete();
        return;
      end
    end

    c = 0;
    while (exp_q.size() > 0 && c < 200) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      in_data  = DW'($urandom);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 3 == 0);
        default: out_ready = 1'($urandom);
      endcase
      if (c == 0) begin
        chk_i("drain_out_valid", int'(out_valid), 1);
        chk_i("drain_nce", int'(nce), 0);
      end
      chk_i("drain_in_ready", int'(in_ready), 0);
      c++;
      #2;
    end
    if (exp_q.size() > 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
      idx_q.delete();
    end

    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk_i("post_in_ready", int'(in_ready), 1);
    chk_i("post_out_valid", int'(out_valid), 0);
    chk_i("post_busy", int'(busy), 0);
    chk_w("post_nx_held", nx, exp_nx);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin : main
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    run_pass(1'b1, 0, 0, -1);  // samples 1..8, y = 100+n
    run_pass(1'b0, 2, 1, -1);  // valid every 3rd cycle, ready 1,0,0,...
    run_pass(1'b0, 0, 2, 9);   // reset in WAIT after three captures
    run_pass(1'b0, 1, 2, -1);  // fresh pass after reset
    run_pass(1'b0, 0, 1, -1);  // back-to-back pass, new lanes everywhere

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hidden_layer_seq.md
Name: hidden_layer_seq

Overview:
- Sequencer directly upstream of neuron_hidden that time-multiplexes one neuron instance across a whole hidden layer.
- Collects N_IN serial 17-bit activations into the packed x bus and streams one weight word per neuron from an external weight ROM.
- Drives the neuron's ce, captures each pipelined y into a result buffer, then drains the results serially to the next layer with a valid/ready handshake.

Parameters:
- N_IN, 8, number of neuron inputs (lanes of the x/w buses)
- N_NEURON, 8, neurons per layer (weight words per pass)
- DW, 17, activation/weight width
- NEURON_LAT, 5, cycles from w/x applied to valid y (mult 1 + adder tree 3 + LUT 1)
- AW, clog2(N_NEURON), weight address / result index width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input activation valid
- in_ready  out  1  sequencer accepts an activation
- in_data  in  DW  activation sample
- w_rd  out  1  weight ROM read enable
- w_addr  out  AW  weight ROM address (= neuron index)
- w_data  in  N_IN*DW  weight word; valid exactly 1 cycle after w_rd
- nx  out  N_IN*DW  packed activations to neuron
- nw  out  N_IN*DW  packed weights to neuron (w_data passed through)
- nce  out  1  neuron clock enable
- ny  in  DW  neuron output
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  DW  result value
- out_idx  out  AW  neuron index of out_data
- busy  out  1  high in every state except LOAD

Behaviour:
- Reset (rst_n=0 at posedge):
  - State→LOAD; all counters 0; nx=0; delay line cleared.
  - Outputs: in_ready=1 in the cycle after reset; w_rd=0, w_addr=0, nce=0, out_valid=0, out_data=0, out_idx=0, busy=0.
  - Reset mid-pass discards all partial inputs and results.
- LOAD:
  - in_ready=1; each in_valid&in_ready writes in_data into lane k of nx (bits DW*(k+1)-1:DW*k), where k is the input counter; k increments.
  - Lane 0 receives the first accepted sample.
  - Acceptance of sample N_IN-1 → ISSUE next cycle; in_ready drops in that same transition.
- ISSUE:
  - w_rd=1, w_addr=n for n=0..N_NEURON-1, one per consecutive cycle, no gaps; nce=1.
  - The issue bit enters a delay line of length 1+NEURON_LAT tagged with n.
  - After n=N_NEURON-1 → WAIT.
- WAIT:
  - nce stays 1 until the last tagged result is captured, then → DRAIN.
  - nce=1 from the first ISSUE cycle through the capture cycle of the last result, 0 otherwise.
- Capture:
  - When the delay-line tap fires for tag n, ny is written to result buffer entry n.
  - Address issued at cycle t → capture at cycle t+1+NEURON_LAT.
  - Total pass from entering ISSUE to entering DRAIN: N_NEURON+1+NEURON_LAT cycles.
- nx is held stable from leaving LOAD until the next LOAD; nw = w_data combinationally.
- DRAIN:
  - out_valid=1, out_data=buf[j], out_idx=j; j increments on out_valid&out_ready.
  - out_data/out_idx must not change while out_valid&!out_ready.
  - After the handshake of j=N_NEURON-1: out_valid=0 and → LOAD with counters cleared. in_ready=1 on the following cycle; no overlap of LOAD and DRAIN.
- Inputs presented outside LOAD are ignored (in_ready=0). out_ready outside DRAIN is ignored.
- No arithmetic is done here; values pass through bit-exact.

Decomposition:
- Shared package nn_pkg:
  - DW, N_IN, N_NEURON, NEURON_LAT defaults.
  - State encoding enum {LOAD, ISSUE, WAIT, DRAIN}.
  - Packing helper to compute lane slice offsets.
- One natural sub-module, tag_delay_line: a shift register of (valid, AW-bit tag), depth 1+NEURON_LAT, synchronous active-low reset.
- Result buffer: a plain register array inside hidden_layer_seq.

Test Plan:
- Load samples 1..8 (17'd1..17'd8) back-to-back → nx = {8,7,...,1} lane-packed, lane0=1; in_ready falls after the 8th.
- ROM model returning word n with all lanes = n; neuron model with fixed 5-cycle latency returning y = 100+addr → w_addr 0..7 on 8 consecutive cycles. Captures at issue+6; out_data sequence 100..107 with out_idx 0..7.
- out_ready toggling 1,0,0,1,... during DRAIN → out_data/out_idx held while stalled; every index delivered exactly once, in order.
- in_valid with gaps (valid every 3rd cycle) → exactly 8 samples accepted; ISSUE starts the cycle after the 8th acceptance.
- rst_n=0 for one cycle during WAIT (after 3 captures) → next cycle: all outputs at reset values, state LOAD; a full new pass yields only the new results.
- Two consecutive passes with different inputs → second pass's nx fully replaces the first; no stale lanes.
